crossbar_out_arbiter: RTL
=========================

Name: crossbar_out_arbiter

Overview:
- Per-output-port scheduler for the switch crossbar.
- Collects o_trans_req from P_PORTS crossbar_point instances targeting one egress port and issues a round-robin, single-cycle, one-hot grant.
- Forwards the granted point's AXIS packet to the egress link.
- Holds ownership until the packet's tlast handshake or an idle-timeout, then re-arbitrates.

Parameters:
- P_PORTS, 4, number of requesting crossbar points (2..8).
- P_SEL_W, 2, owner index width (= clog2(P_PORTS)).
- P_TIMEOUT, 16'd1024, max consecutive cycles without a handshake on the owner before forced release.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_trans_req  in  P_PORTS  request from each crossbar point (level, held until granted)
- o_trans_grant  out  P_PORTS  one-hot grant pulse, one cycle
- s_axis_tvalid  in  P_PORTS  per-point tvalid
- s_axis_tdata  in  P_PORTS*64  per-point data, point i at [64i+63:64i]
- s_axis_tlast  in  P_PORTS  per-point tlast
- s_axis_tkeep  in  P_PORTS*8  per-point keep
- s_axis_tready  out  P_PORTS  ready back to each point
- m_axis_tvalid  out  1  egress valid
- m_axis_tdata  out  64  egress data
- m_axis_tlast  out  1  egress last
- m_axis_tkeep  out  8  egress keep
- m_axis_tready  in  1  egress ready
- o_busy  out  1  high while a point owns the egress
- o_owner  out  P_SEL_W  current/last owner index
- o_timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (i_rst_n low, async): state IDLE.
  - o_trans_grant=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=8'hff.
  - o_busy=0, o_owner=P_PORTS-1 (so port 0 wins first), o_timeout=0, timeout counter=0.
- FSM has three states: IDLE, GRANT, BUSY.
- IDLE:
  - If any i_trans_req bit is set, select the first set bit searching from index (o_owner+1) mod P_PORTS upward with wrap.
  - Register the selection into o_owner and go to GRANT.
  - If no request, stay in IDLE.
- GRANT:
  - o_trans_grant[o_owner]=1 for exactly this cycle.
  - o_busy=1 from this cycle on.
  - Clear the counter and go to BUSY.
  - Requests dropping during GRANT are ignored.
- BUSY:
  - Combinational mux: m_axis_tvalid/tdata/tlast/tkeep = s_axis_*[o_owner].
  - s_axis_tready[o_owner] = m_axis_tready; all other bits of s_axis_tready = 0.
  - Non-owner tvalid is ignored.
- Packet end: on m_axis_tvalid & m_axis_tready & m_axis_tlast, go to IDLE next cycle with o_busy=0.
  - o_owner keeps its value so it serves as the round-robin pointer.
  - At least one IDLE cycle always separates packets.
- Timeout counter:
  - Increments each BUSY cycle without an owner handshake.
  - Clears on any owner handshake.
  - Saturates at 16 bits.
- Forced release: when the counter reaches P_TIMEOUT-1 with no handshake that cycle:
  - Pulse o_timeout, go to IDLE, drop ownership.
  - Mid-packet beats are discarded and tlast is not forged.
  - The pointer advances past the timed-out point.
- Outside BUSY: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=8'hff.
- Simultaneous events:
  - A tlast handshake in the same cycle the counter would expire is a normal end; o_timeout stays 0.
  - A new request from the current owner is honored only after the pointer rotation, so no point starves.
- A single requester is re-granted every 3 cycles minimum (IDLE, GRANT, BUSY).
- Asynchronous reset mid-packet returns all outputs to reset values immediately; no state survives.

Test Plan:
- Single request: i_trans_req=4'b0001 after reset -> o_trans_grant=4'b0001 pulse 2 cycles later. A 4-beat packet with tlast keep 8'h0f appears unchanged on m_axis. o_busy falls the cycle after the tlast handshake.
- Round-robin fairness: all four requests held high, each sending a 2-beat packet -> grant order 0,1,2,3,0. No point granted twice before the others.
- Backpressure: m_axis_tready toggles 1,0,1,0 during a 5-beat packet -> s_axis_tready[owner] mirrors m_axis_tready. Non-owner tready=0. Data order is preserved. Counter never reaches timeout.
- Timeout: P_TIMEOUT=8, owner granted but never asserts tvalid -> o_timeout pulses 8 cycles after entering BUSY. The next pending requester is granted.
- Tlast coincident with expiry: the last handshake lands on the cycle the counter would expire -> normal release, o_timeout=0.
- Reset mid-packet: i_rst_n low during beat 2 of 4 -> m_axis_tvalid=0, o_trans_grant=0, o_owner=P_PORTS-1 immediately. After release, port 0 has highest priority.

Source files
------------

// File: rtl/crossbar_out_arbiter.sv
// Egress-port scheduler: round-robin grant among crossbar points, then forwards the
// owner's AXIS packet until tlast or an idle timeout forces release.
module crossbar_out_arbiter #(
  parameter int          P_PORTS   = 4,
  parameter int          P_SEL_W   = 2,
  parameter logic [15:0] P_TIMEOUT = 16'd1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [P_PORTS-1:0]     i_trans_req,
  output logic [P_PORTS-1:0]     o_trans_grant,
  input  logic [P_PORTS-1:0]     s_axis_tvalid,
  input  logic [P_PORTS*64-1:0]  s_axis_tdata,
  input  logic [P_PORTS-1:0]     s_axis_tlast,
  input  logic [P_PORTS*8-1:0]   s_axis_tkeep,
  output logic [P_PORTS-1:0]     s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [63:0]            m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [7:0]             m_axis_tkeep,
  input  logic                   m_axis_tready,
  output logic                   o_busy,
  output logic [P_SEL_W-1:0]     o_owner,
  output logic                   o_timeout,
  output logic [1:0]             o_dbg_state
);

  // AXIS handshake: a beat transfers on a cycle where tvalid and tready are both
  // high; only the owner's tvalid/tready pair is ever connected to the egress.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [P_SEL_W-1:0] owner_q, owner_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [P_SEL_W-1:0] rr_sel;
  logic               rr_found;
  logic               own_hs;

  assign own_hs = (state_q == S_BUSY) && s_axis_tvalid[owner_q] && m_axis_tready;

  // Search starts one past the last owner so the previous winner goes last.
  always_comb begin
    rr_sel   = owner_q;
    rr_found = 1'b0;
    for (int k = 1; k <= P_PORTS; k++) begin
      if (!rr_found && i_trans_req[(int'(owner_q) + k) % P_PORTS]) begin
        rr_sel   = P_SEL_W'((int'(owner_q) + k) % P_PORTS);
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= P_SEL_W'(P_PORTS - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|i_trans_req) begin
          owner_d = rr_sel;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // A handshake always wins over expiry, so a coincident tlast ends normally.
        if (own_hs) begin
          cnt_d = '0;
          if (s_axis_tlast[owner_q]) state_d = S_IDLE;
        end else if (cnt_q == P_TIMEOUT - 16'd1) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q != 16'hffff) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_trans_grant = '0;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tkeep  = 8'hff;
    o_busy        = (state_q != S_IDLE);
    o_owner       = owner_q;
    o_timeout     = timeout_q;
    o_dbg_state   = state_q;
    if (state_q == S_GRANT) o_trans_grant[owner_q] = 1'b1;
    if (state_q == S_BUSY) begin
      m_axis_tvalid          = s_axis_tvalid[owner_q];
      m_axis_tdata           = s_axis_tdata[int'(owner_q)*64 +: 64];
      m_axis_tlast           = s_axis_tlast[owner_q];
      m_axis_tkeep           = s_axis_tkeep[int'(owner_q)*8 +: 8];
      s_axis_tready[owner_q] = m_axis_tready;
    end
  end

endmodule
